// File: rtl/bcd_word_assembler.sv
// BCD word assembler: shifts BCD digits MSB-first into an N-bit word.
// Optional non-BCD digit rejection is enabled with macro BCD_CHECK_EN.
module bcd_word_assembler #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   digit_in,
  input  logic         digit_valid,
  output logic         digit_ready,
  input  logic         commit,
  input  logic         clear,
  output logic [N-1:0] word_out,
  output logic         word_valid,
  output logic [3:0]   digit_count,
  output logic         digit_err
);

  localparam int CAP = N / 4;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    EMIT
  } state_t;

  state_t       state_q;
  logic [N-1:0] acc_q;
  logic [N-1:0] acc_d;
  logic [N-1:0] word_q;
  logic [3:0]   cnt_q;
  logic [3:0]   cnt_d;
  logic         wvalid_q;
  logic         bcd_ok;
  logic         take;
  logic         fire;

`ifdef BCD_CHECK_EN
  logic err_q;

  assign bcd_ok    = (digit_in <= 4'd9);
  assign digit_err = err_q;

  // Pulse the error flag for one cycle after a rejected digit
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= !clear && digit_valid && digit_ready && !bcd_ok;
    end
  end
`else
  assign bcd_ok    = 1'b1;
  assign digit_err = 1'b0;
`endif

  assign digit_ready = (state_q != EMIT);
  assign take        = digit_valid && digit_ready && bcd_ok;
  assign word_out    = word_q;
  assign word_valid  = wvalid_q;
  assign digit_count = cnt_q;

  // Next accumulator and count with this cycle's digit folded in
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (take) begin
      acc_d = {acc_q[N-5:0], digit_in};
      cnt_d = cnt_q + 4'd1;
    end
    fire = (take && (cnt_d == 4'(CAP))) ||
           (commit && (cnt_d != 4'd0));
  end

  // Control FSM with registered word and pulse outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      cnt_q    <= 4'd0;
      word_q   <= '0;
      wvalid_q <= 1'b0;
    end else if (clear) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      cnt_q    <= 4'd0;
      wvalid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, COLLECT: begin
          wvalid_q <= fire;
          if (fire) begin
            state_q <= EMIT;
            word_q  <= acc_d;
            acc_q   <= '0;
            cnt_q   <= 4'd0;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            if (cnt_d != 4'd0) begin
              state_q <= COLLECT;
            end
          end
        end
        EMIT: begin
          state_q  <= IDLE;
          wvalid_q <= 1'b0;
        end
        default: begin
          state_q  <= IDLE;
          wvalid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_word_assembler.sv
// Directed bench for bcd_word_assembler.
// Per-cycle vector table plus hand sequences for reset and clear-in-EMIT.
module tb_bcd_word_assembler;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  digit_in;
  logic        digit_valid;
  logic        digit_ready;
  logic        commit;
  logic        clear;
  logic [31:0] word_out;
  logic        word_valid;
  logic [3:0]  digit_count;
  logic        digit_err;

  int n_chk = 0;
  int n_fail = 0;

  bcd_word_assembler #(.N(32)) dut (
    .clk(clk),
    .reset(reset),
    .digit_in(digit_in),
    .digit_valid(digit_valid),
    .digit_ready(digit_ready),
    .commit(commit),
    .clear(clear),
    .word_out(word_out),
    .word_valid(word_valid),
    .digit_count(digit_count),
    .digit_err(digit_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        clr;
    logic        cmt;
    logic        dv;
    logic [3:0]  d;
    logic        wv;
    logic [31:0] w;
    logic [3:0]  cnt;
    logic        rdy;
    logic        err;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic clr, input logic cmt, input logic dv,
                     input logic [3:0] d, input logic wv,
                     input logic [31:0] w, input logic [3:0] cnt,
                     input logic rdy, input logic err);
    vec_t v;
    v.clr = clr; v.cmt = cmt; v.dv = dv; v.d = d;
    v.wv = wv; v.w = w; v.cnt = cnt; v.rdy = rdy; v.err = err;
    tv.push_back(v);
  endtask

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic clr, input logic cmt,
                       input logic dv, input logic [3:0] d);
    reset = rst; clear = clr; commit = cmt;
    digit_valid = dv; digit_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int idx, input logic wv,
                         input logic [31:0] w, input logic [3:0] cnt,
                         input logic rdy, input logic err);
    chk({tag, ".word_valid"}, idx, {31'b0, word_valid}, {31'b0, wv});
    chk({tag, ".word_out"}, idx, word_out, w);
    chk({tag, ".digit_count"}, idx, {28'b0, digit_count}, {28'b0, cnt});
    chk({tag, ".digit_ready"}, idx, {31'b0, digit_ready}, {31'b0, rdy});
    chk({tag, ".digit_err"}, idx, {31'b0, digit_err}, {31'b0, err});
  endtask

  initial begin
    // eight digits fill the word
    for (int i = 1; i <= 7; i++)
      add(0, 0, 1, 4'(i), 0, 32'h0, 4'(i), 1, 0);
    add(0, 0, 1, 4'd8, 1, 32'h12345678, 0, 0, 0);
    add(0, 0, 1, 4'd9, 0, 32'h12345678, 0, 1, 0);
    // early commit, commit in EMIT and in IDLE ignored
    add(0, 0, 1, 4'd4, 0, 32'h12345678, 1, 1, 0);
    add(0, 0, 1, 4'd2, 0, 32'h12345678, 2, 1, 0);
    add(0, 1, 0, 4'd0, 1, 32'h00000042, 0, 0, 0);
    add(0, 1, 0, 4'd0, 0, 32'h00000042, 0, 1, 0);
    add(0, 1, 0, 4'd0, 0, 32'h00000042, 0, 1, 0);
    // commit on the same edge as the last digit
    add(0, 0, 1, 4'd9, 0, 32'h00000042, 1, 1, 0);
    add(0, 0, 1, 4'd9, 0, 32'h00000042, 2, 1, 0);
    add(0, 1, 1, 4'd9, 1, 32'h00000999, 0, 0, 0);
    add(0, 0, 0, 4'd0, 0, 32'h00000999, 0, 1, 0);
    // clear beats a digit, then digit+commit from IDLE
    add(0, 0, 1, 4'd1, 0, 32'h00000999, 1, 1, 0);
    add(0, 0, 1, 4'd2, 0, 32'h00000999, 2, 1, 0);
    add(0, 0, 1, 4'd3, 0, 32'h00000999, 3, 1, 0);
    add(1, 1, 1, 4'd4, 0, 32'h00000999, 0, 1, 0);
    add(0, 1, 1, 4'd5, 1, 32'h00000005, 0, 0, 0);
    add(0, 0, 0, 4'd0, 0, 32'h00000005, 0, 1, 0);
    // non-BCD digit handling
    add(0, 0, 1, 4'd1, 0, 32'h00000005, 1, 1, 0);
`ifdef BCD_CHECK_EN
    add(0, 0, 1, 4'hA, 0, 32'h00000005, 1, 1, 1);
    add(0, 1, 1, 4'd2, 1, 32'h00000012, 0, 0, 0);
    add(0, 0, 0, 4'd0, 0, 32'h00000012, 0, 1, 0);
    add(0, 0, 1, 4'd3, 0, 32'h00000012, 1, 1, 0);
    add(0, 1, 1, 4'hF, 1, 32'h00000003, 0, 0, 1);
    add(0, 0, 0, 4'd0, 0, 32'h00000003, 0, 1, 0);
`else
    add(0, 0, 1, 4'hA, 0, 32'h00000005, 2, 1, 0);
    add(0, 1, 1, 4'd2, 1, 32'h000001A2, 0, 0, 0);
    add(0, 0, 0, 4'd0, 0, 32'h000001A2, 0, 1, 0);
    add(0, 0, 1, 4'd3, 0, 32'h000001A2, 1, 1, 0);
    add(0, 1, 1, 4'hF, 1, 32'h0000003F, 0, 0, 0);
    add(0, 0, 0, 4'd0, 0, 32'h0000003F, 0, 1, 0);
`endif

    // reset state
    drive(1, 0, 0, 0, 4'd0);
    drive(1, 1, 1, 1, 4'd3);
    chk_all("reset", 0, 0, 32'h0, 0, 1, 0);

    for (int i = 0; i < tv.size(); i++) begin
      drive(0, tv[i].clr, tv[i].cmt, tv[i].dv, tv[i].d);
      chk_all("vec", i, tv[i].wv, tv[i].w, tv[i].cnt, tv[i].rdy, tv[i].err);
    end

    // reset mid-word wins over digit and commit
    for (int i = 1; i <= 5; i++)
      drive(0, 0, 0, 1, 4'(i));
    chk("mid.count", 5, {28'b0, digit_count}, 32'd5);
    drive(1, 1, 1, 1, 4'd7);
    chk_all("midrst", 0, 0, 32'h0, 0, 1, 0);
    drive(0, 0, 0, 0, 4'd0);
    chk_all("midrst", 1, 0, 32'h0, 0, 1, 0);
    for (int i = 8; i >= 1; i--)
      drive(0, 0, 0, 1, 4'(i));
    chk_all("refill", 0, 1, 32'h87654321, 0, 0, 0);

    // clear during EMIT keeps the pulse already on the output
    reset = 0; clear = 1; commit = 0; digit_valid = 0;
    #1;
    chk("emitclr.pulse", 0, {31'b0, word_valid}, 32'd1);
    @(posedge clk);
    #1;
    chk_all("emitclr", 1, 0, 32'h87654321, 0, 1, 0);
    drive(0, 0, 0, 0, 4'd0);
    chk_all("emitclr", 2, 0, 32'h87654321, 0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
